// File: rtl/avalon_memory_bridge_if.sv
// Avalon-MM slave bus plus block-RAM port bundle for avalon_memory_bridge.
// slave modport: the bridge's view. master modport: the driving agent/RAM view.
interface avalon_memory_bridge_if #(
    parameter int BUSWIDTH     = 32,
    parameter int DATAWIDTH    = 32,
    parameter int ADDRESSWIDTH = 8
) ();
    // Avalon-MM side
    logic                    read;
    logic                    write;
    logic [ADDRESSWIDTH-1:0] address;
    logic [BUSWIDTH/8-1:0]   byteenable;
    logic [BUSWIDTH-1:0]     data_in;
    logic                    waitrequest;
    logic                    read_valid;
    logic [BUSWIDTH-1:0]     data_out;
    // Block-RAM side
    logic                    mem_read_en;
    logic                    mem_write_en;
    logic [ADDRESSWIDTH-1:0] mem_address;
    logic [DATAWIDTH-1:0]    mem_data_in;
    logic [DATAWIDTH-1:0]    mem_data_out;

    modport slave (
        input  read, write, address, byteenable, data_in, mem_data_out,
        output waitrequest, read_valid, data_out,
               mem_read_en, mem_write_en, mem_address, mem_data_in
    );

    modport master (
        output read, write, address, byteenable, data_in, mem_data_out,
        input  waitrequest, read_valid, data_out,
               mem_read_en, mem_write_en, mem_address, mem_data_in
    );
endinterface

// File: rtl/avalon_memory_bridge.sv
// Avalon-MM slave to single synchronous block RAM with fixed read latency.
// Byte-enable writes become an internal read-modify-write against a
// word-write-only RAM, back-pressured with waitrequest. In-flight reads are
// tracked by a LATENCY-deep pipeline.
// Optional feature: define AVALON_MEM_FWD_EN to forward RAM writes into
// in-flight pipeline stages (read-after-write forwarding).
module avalon_memory_bridge #(
    parameter int BUSWIDTH     = 32,
    parameter int DATAWIDTH    = 32,
    parameter int DATADEPTH    = 256,
    parameter int LATENCY      = 1,
    parameter int ADDRESSWIDTH = $clog2(DATADEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    avalon_memory_bridge_if.slave   bus
);

    localparam int LANES = DATAWIDTH / 8;
    localparam int CW    = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        RMW_WAIT,
        RMW_WRITE
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_count;

    // Per-stage tracking of issued RAM reads; stage LATENCY-1 retires.
    logic [LATENCY-1:0]  r_pv;
    logic [LATENCY-1:0]  r_pint;

`ifdef AVALON_MEM_FWD_EN
    logic [ADDRESSWIDTH-1:0] r_paddr [LATENCY];
    logic [DATAWIDTH-1:0]    r_pfwd  [LATENCY];
    logic [LANES-1:0]        r_pmask [LATENCY];
    logic [DATAWIDTH-1:0]    w_nfwd  [LATENCY];
    logic [LANES-1:0]        w_nmask [LATENCY];
    logic [LANES-1:0]        w_wr_mask;
`endif

    logic [LANES-1:0]     w_lanes;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_partial;
    logic                 w_wait;
    logic                 w_issue_rd;
    logic                 w_issue_int;
    logic                 w_wr_en;
    logic [DATAWIDTH-1:0] w_wr_data;
    logic [DATAWIDTH-1:0] w_ret_word;
    logic [DATAWIDTH-1:0] w_merge;
    logic                 w_read_valid;
    logic                 w_unused;

    // Byte lanes above the RAM word width are ignored.
    assign w_lanes   = bus.byteenable[LANES-1:0];
    assign w_full    = &w_lanes;
    assign w_empty   = ~|w_lanes;
    assign w_partial = !w_full && !w_empty;
    assign w_unused  = ^{bus.byteenable, bus.data_in};

    // Word leaving the last pipeline stage, with forwarded lanes applied.
`ifdef AVALON_MEM_FWD_EN
    always_comb begin
        w_ret_word = bus.mem_data_out;
        for (int unsigned j = 0; j < LANES; j++) begin
            if (r_pmask[LATENCY-1][j]) begin
                w_ret_word[j*8 +: 8] = r_pfwd[LATENCY-1][j*8 +: 8];
            end
        end
    end
`else
    assign w_ret_word = bus.mem_data_out;
`endif

    // RMW merge: enabled lanes from the bus, the rest from the returned word.
    always_comb begin
        w_merge = w_ret_word;
        for (int unsigned j = 0; j < LANES; j++) begin
            if (w_lanes[j]) begin
                w_merge[j*8 +: 8] = bus.data_in[j*8 +: 8];
            end
        end
    end

    // Command decode: back-pressure, RAM strobes and write data per state.
    always_comb begin
        w_wait      = 1'b0;
        w_issue_rd  = 1'b0;
        w_issue_int = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_data   = bus.data_in[DATAWIDTH-1:0];
        if (reset) begin
            unique case (r_state)
                IDLE: begin
                    if (bus.write) begin
                        if (w_full) begin
                            w_wr_en = 1'b1;
                        end else if (w_partial) begin
                            w_wait      = 1'b1;
                            w_issue_rd  = 1'b1;
                            w_issue_int = 1'b1;
                        end
                    end else if (bus.read) begin
                        w_issue_rd = 1'b1;
                    end
                end
                RMW_WAIT: begin
                    w_wait = 1'b1;
                end
                RMW_WRITE: begin
                    if (bus.write) begin
                        w_wr_en   = 1'b1;
                        w_wr_data = w_merge;
                    end
                end
                default: begin
                    w_wait = 1'b0;
                end
            endcase
        end
    end

    assign w_read_valid     = r_pv[LATENCY-1] && !r_pint[LATENCY-1];
    assign bus.waitrequest  = w_wait;
    assign bus.mem_read_en  = w_issue_rd;
    assign bus.mem_write_en = w_wr_en;
    assign bus.mem_address  = bus.address;
    assign bus.mem_data_in  = w_wr_data;
    assign bus.read_valid   = w_read_valid;
    assign bus.data_out     = w_read_valid ? BUSWIDTH'(w_ret_word) : '0;

    // RMW sequencer: IDLE -> RMW_WAIT (LATENCY-1 cycles) -> RMW_WRITE -> IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.write && w_partial) begin
                        r_count <= CNT_INIT;
                        r_state <= (LATENCY == 1) ? RMW_WRITE : RMW_WAIT;
                    end
                end
                RMW_WAIT: begin
                    if (r_count > CNT_ONE) begin
                        r_count <= r_count - CNT_ONE;
                    end else begin
                        r_count <= '0;
                        r_state <= RMW_WRITE;
                    end
                end
                RMW_WRITE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef AVALON_MEM_FWD_EN
    // Every RAM write writes whole words, so all lanes are forwarded.
    assign w_wr_mask = '1;

    // Forward the current RAM write into matching in-flight stages; a later
    // write simply overwrites an earlier one as the stage moves along.
    always_comb begin
        for (int unsigned k = 0; k < LATENCY; k++) begin
            w_nfwd[k]  = r_pfwd[k];
            w_nmask[k] = r_pmask[k];
            if (w_wr_en && r_pv[k] && (r_paddr[k] == bus.address)) begin
                for (int unsigned j = 0; j < LANES; j++) begin
                    if (w_wr_mask[j]) begin
                        w_nfwd[k][j*8 +: 8] = w_wr_data[j*8 +: 8];
                        w_nmask[k][j]       = 1'b1;
                    end
                end
            end
        end
    end
`endif

    // Read-tracking pipeline: stage 0 captures this cycle's RAM read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pv   <= '0;
            r_pint <= '0;
`ifdef AVALON_MEM_FWD_EN
            for (int unsigned k = 0; k < LATENCY; k++) begin
                r_paddr[k] <= '0;
                r_pfwd[k]  <= '0;
                r_pmask[k] <= '0;
            end
`endif
        end else begin
            r_pv[0]   <= w_issue_rd;
            r_pint[0] <= w_issue_int;
            for (int unsigned k = 1; k < LATENCY; k++) begin
                r_pv[k]   <= r_pv[k-1];
                r_pint[k] <= r_pint[k-1];
            end
`ifdef AVALON_MEM_FWD_EN
            r_paddr[0] <= bus.address;
            r_pfwd[0]  <= '0;
            r_pmask[0] <= '0;
            for (int unsigned k = 1; k < LATENCY; k++) begin
                r_paddr[k] <= r_paddr[k-1];
                r_pfwd[k]  <= w_nfwd[k-1];
                r_pmask[k] <= w_nmask[k-1];
            end
`endif
        end
    end

endmodule

// File: tb/tb_avalon_memory_bridge.sv
// Bench for avalon_memory_bridge: a 32/32-bit LATENCY=2 instance checked by a
// scoreboard against a golden memory, plus a 16-bit-word LATENCY=1 instance.
module tb_avalon_memory_bridge;

    localparam int LAT = 2;
`ifdef AVALON_MEM_FWD_EN
    // With forwarding a read sees every write accepted before its retire cycle.
    localparam int FWD_DELAY = LAT - 1;
`else
    // Without forwarding a read sees memory as it was when it was accepted.
    localparam int FWD_DELAY = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] preload(input int unsigned a);
        logic [31:0] v;
        v = a * 32'h11111111;
        if (a == 32'h40) v = 32'h11223344;
        return v;
    endfunction

    // ------------------------------------------------------------ DUT 1
    avalon_memory_bridge_if #(.BUSWIDTH(32), .DATAWIDTH(32), .ADDRESSWIDTH(8)) bus ();
    avalon_memory_bridge #(
        .BUSWIDTH(32), .DATAWIDTH(32), .DATADEPTH(256), .LATENCY(LAT), .ADDRESSWIDTH(8)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    logic [31:0] ram [256];
    logic [31:0] rq [LAT];
    bit ram_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 256; i++) ram[i] <= preload(i);
            ram_ready = 1'b1;
        end else if (bus.mem_write_en) begin
            ram[bus.mem_address] <= bus.mem_data_in;
        end
        rq[0] <= ram[bus.mem_address];
        for (int i = 1; i < LAT; i++) rq[i] <= rq[i-1];
    end
    assign bus.mem_data_out = rq[LAT-1];

    // ------------------------------------------------------------ scoreboard
    typedef struct { logic [31:0] data; int unsigned due; } exp_t;
    typedef struct { logic [7:0] addr; int unsigned push_at; int unsigned due; } pend_t;
    exp_t  exp_q [$];
    pend_t pend_q [$];
    logic [31:0] gold [256];
    bit gold_ready = 1'b0;
    int unsigned rd_cnt = 0;
    int unsigned wr_cnt = 0;
    logic [31:0] wr_last = '0;

    always @(negedge clk) begin
        exp_t e;
        pend_t p;
        logic [31:0] w;
        if (!gold_ready) begin
            for (int i = 0; i < 256; i++) gold[i] = preload(i);
            gold_ready = 1'b1;
        end
        if (bus.mem_read_en) rd_cnt++;
        if (bus.mem_write_en) begin
            wr_cnt++;
            wr_last = bus.mem_data_in;
        end
        if (!reset) begin
            exp_q.delete();
            pend_q.delete();
        end else begin
            if (bus.read_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_read_valid", {31'b0, bus.read_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("read_data", bus.data_out, e.data);
                    check("read_latency", cyc, e.due);
                end
            end else begin
                check("idle_data_out", bus.data_out, 32'd0);
            end
            if (bus.write && !bus.waitrequest) begin
                w = gold[bus.address];
                for (int j = 0; j < 4; j++)
                    if (bus.byteenable[j]) w[j*8 +: 8] = bus.data_in[j*8 +: 8];
                gold[bus.address] = w;
            end else if (bus.read && !bus.waitrequest) begin
                pend_q.push_back('{bus.address, cyc + FWD_DELAY, cyc + LAT});
            end
            while (pend_q.size() > 0 && pend_q[0].push_at == cyc) begin
                p = pend_q.pop_front();
                exp_q.push_back('{gold[p.addr], p.due});
            end
        end
    end

    task automatic issue(input bit rd, input bit wr, input logic [7:0] a,
                         input logic [3:0] be, input logic [31:0] d, output int unsigned occ);
        occ = 0;
        bus.read = rd; bus.write = wr; bus.address = a; bus.byteenable = be; bus.data_in = d;
        do begin
            @(negedge clk);
            occ++;
        end while (bus.waitrequest && occ < 40);
        if (bus.waitrequest) check("accept_timeout", {31'b0, bus.waitrequest}, 32'd0);
        @(posedge clk); #1;
        bus.read = 1'b0; bus.write = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        idle(LAT + 3);
        check(nm, exp_q.size() + pend_q.size(), 32'd0);
    endtask

    // ------------------------------------------------------------ DUT 2
    avalon_memory_bridge_if #(.BUSWIDTH(32), .DATAWIDTH(16), .ADDRESSWIDTH(4)) bus2 ();
    avalon_memory_bridge #(
        .BUSWIDTH(32), .DATAWIDTH(16), .DATADEPTH(16), .LATENCY(1), .ADDRESSWIDTH(4)
    ) dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    logic [15:0] ram2 [16];
    logic [15:0] rq2;
    bit ram2_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram2_ready) begin
            for (int i = 0; i < 16; i++) ram2[i] <= 16'(i * 16'h1111);
            ram2_ready = 1'b1;
        end else if (bus2.mem_write_en) begin
            ram2[bus2.mem_address] <= bus2.mem_data_in;
        end
        rq2 <= ram2[bus2.mem_address];
    end
    assign bus2.mem_data_out = rq2;

    int unsigned wr2_cnt = 0;
    logic [15:0] wr2_last = '0;
    always @(negedge clk) begin
        if (bus2.mem_write_en) begin
            wr2_cnt++;
            wr2_last = bus2.mem_data_in;
        end
    end

    task automatic issue2(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d,
                          output int unsigned occ);
        occ = 0;
        bus2.write = 1'b1; bus2.address = a; bus2.byteenable = be; bus2.data_in = d;
        do begin
            @(negedge clk);
            occ++;
        end while (bus2.waitrequest && occ < 40);
        if (bus2.waitrequest) check("accept_timeout2", {31'b0, bus2.waitrequest}, 32'd0);
        @(posedge clk); #1;
        bus2.write = 1'b0;
    endtask

    task automatic read2(input logic [3:0] a, input logic [31:0] exp);
        bus2.read = 1'b1; bus2.address = a;
        @(negedge clk);
        check("rd16_wait", {31'b0, bus2.waitrequest}, 32'd0);
        @(posedge clk); #1;
        bus2.read = 1'b0;
        @(negedge clk);
        check("rd16_valid", {31'b0, bus2.read_valid}, 32'd1);
        check("rd16_data", bus2.data_out, exp);
        @(posedge clk); #1;
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        int unsigned occ;
        int unsigned c_rd;
        int unsigned c_wr;
        int unsigned op;
        logic [7:0] a;
        logic [3:0] be;

        bus.read = 1'b0; bus.write = 1'b1; bus.address = 8'h10;
        bus.byteenable = 4'b0011; bus.data_in = '0;
        bus2.read = 1'b0; bus2.write = 1'b0; bus2.address = '0;
        bus2.byteenable = '0; bus2.data_in = '0;

        // Reset: outputs quiet even with a partial write presented.
        repeat (3) @(posedge clk);
        #1;
        check("rst_waitrequest", {31'b0, bus.waitrequest}, 32'd0);
        check("rst_read_valid", {31'b0, bus.read_valid}, 32'd0);
        check("rst_data_out", bus.data_out, 32'd0);
        check("rst_mem_read_en", {31'b0, bus.mem_read_en}, 32'd0);
        check("rst_mem_write_en", {31'b0, bus.mem_write_en}, 32'd0);
        bus.write = 1'b0;
        reset = 1'b1;
        idle(1);

        // Back-to-back reads 0..7.
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, 1'b0, 8'(i), 4'h0, 32'h0, occ);
            check("b2b_read_occ", occ, 32'd1);
        end
        drain("drain_b2b");

        // Full write then delayed read-back.
        issue(1'b0, 1'b1, 8'h05, 4'hF, 32'hDEADBEEF, occ);
        check("full_write_occ", occ, 32'd1);
        idle(2);
        issue(1'b1, 1'b0, 8'h05, 4'h0, 32'h0, occ);
        drain("drain_full");

        // Partial write: one internal read, one merged word write.
        c_rd = rd_cnt; c_wr = wr_cnt;
        issue(1'b0, 1'b1, 8'h40, 4'b0010, 32'h0000AB00, occ);
        check("partial_occ", occ, LAT + 1);
        check("partial_rd_cnt", rd_cnt - c_rd, 32'd1);
        check("partial_wr_cnt", wr_cnt - c_wr, 32'd1);
        check("partial_wr_data", wr_last, 32'h1122AB44);
        issue(1'b1, 1'b0, 8'h40, 4'h0, 32'h0, occ);
        drain("drain_partial");

        // Empty write: accepted in one cycle, no RAM access.
        c_rd = rd_cnt; c_wr = wr_cnt;
        issue(1'b0, 1'b1, 8'h41, 4'h0, 32'hFFFFFFFF, occ);
        check("empty_occ", occ, 32'd1);
        check("empty_ram_access", (rd_cnt - c_rd) + (wr_cnt - c_wr), 32'd0);

        // Write then immediate read; read then immediate write.
        issue(1'b0, 1'b1, 8'h03, 4'hF, 32'h12345678, occ);
        issue(1'b1, 1'b0, 8'h03, 4'h0, 32'h0, occ);
        issue(1'b1, 1'b0, 8'h06, 4'h0, 32'h0, occ);
        issue(1'b0, 1'b1, 8'h06, 4'hF, 32'hCAFEF00D, occ);
        drain("drain_hazard");

        // Reset during RMW_WAIT: RMW abandoned, no RAM write.
        c_wr = wr_cnt;
        bus.write = 1'b1; bus.read = 1'b0; bus.address = 8'h50;
        bus.byteenable = 4'b0001; bus.data_in = 32'h000000AA;
        @(negedge clk);
        check("rmw_wait_c0", {31'b0, bus.waitrequest}, 32'd1);
        @(posedge clk); #2;
        check("rmw_wait_c1", {31'b0, bus.waitrequest}, 32'd1);
        reset = 1'b0;
        #1;
        check("rst_mid_waitrequest", {31'b0, bus.waitrequest}, 32'd0);
        check("rst_mid_read_valid", {31'b0, bus.read_valid}, 32'd0);
        bus.write = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        idle(LAT + 2);
        check("rst_mid_no_write", wr_cnt - c_wr, 32'd0);
        issue(1'b1, 1'b0, 8'h50, 4'h0, 32'h0, occ);
        drain("drain_rst");

        // Randomized traffic over a small address window to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 9);
            a  = 8'($urandom_range(0, 15));
            be = 4'($urandom_range(1, 14));
            case (op)
                0, 1, 2, 3: issue(1'b1, 1'b0, a, 4'h0, $urandom, occ);
                4, 5:       issue(1'b0, 1'b1, a, 4'hF, $urandom, occ);
                6, 7:       issue(1'b0, 1'b1, a, be, $urandom, occ);
                8:          issue(1'b0, 1'b1, a, 4'h0, $urandom, occ);
                default:    issue(1'b1, 1'b1, a, 4'($urandom), $urandom, occ);
            endcase
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        drain("drain_random");

        // 16-bit RAM words on a 32-bit bus.
        c_wr = wr2_cnt;
        issue2(4'd2, 4'b1111, 32'hFFFFBEEF, occ);
        check("w16_occ", occ, 32'd1);
        check("w16_wr_cnt", wr2_cnt - c_wr, 32'd1);
        check("w16_wr_data", {16'h0, wr2_last}, 32'h0000BEEF);
        read2(4'd2, 32'h0000BEEF);
        issue2(4'd2, 4'b0110, 32'h0000CA00, occ);
        check("p16_occ", occ, 32'd2);
        check("p16_wr_data", {16'h0, wr2_last}, 32'h0000CAEF);
        read2(4'd2, 32'h0000CAEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
